// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny accumulator CPU: opcodes, FSM states and default sizes.
package tiny_cpu_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_PCW   = 8;
  localparam int DEF_NREGS = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_ST   = 4'h7,
    OP_LD   = 4'h8,
    OP_ADDI = 4'h9,
    OP_JMP  = 4'hA,
    OP_JZ   = 4'hB,
    OP_JC   = 4'hC,
    OP_IN   = 4'hD,
    OP_OUT  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_INWAIT,
    S_OUTWAIT,
    S_HALT
  } state_t;

endpackage

// File: rtl/tiny_cpu_alu.sv
// Combinational ALU: result, zero flag, carry/borrow and write enables for acc and C.
// Shift operations on opcode 0 exist only when TINY_CPU_SHIFT_EN is defined.
module tiny_cpu_alu
  import tiny_cpu_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  opcode_t         op,
  input  logic [DW-1:0]   acc,
  input  logic [DW-1:0]   imm,
  input  logic [DW-1:0]   rval,
  output logic [DW-1:0]   result,
  output logic            z,
  output logic            c,
  output logic            acc_we,
  output logic            c_we
);

  logic [DW:0] sum;

  always_comb begin
    sum    = '0;
    result = acc;
    c      = 1'b0;
    acc_we = 1'b0;
    c_we   = 1'b0;
    case (op)
      OP_LDI:  begin result = imm; acc_we = 1'b1; end
      OP_ADD:  begin
        sum = {1'b0, acc} + {1'b0, rval};
        result = sum[DW-1:0]; c = sum[DW]; acc_we = 1'b1; c_we = 1'b1;
      end
      // the extra top bit of the difference is the borrow (acc < R)
      OP_SUB:  begin
        sum = {1'b0, acc} - {1'b0, rval};
        result = sum[DW-1:0]; c = sum[DW]; acc_we = 1'b1; c_we = 1'b1;
      end
      OP_AND:  begin result = acc & rval; acc_we = 1'b1; end
      OP_OR:   begin result = acc | rval; acc_we = 1'b1; end
      OP_XOR:  begin result = acc ^ rval; acc_we = 1'b1; end
      OP_LD:   begin result = rval; acc_we = 1'b1; end
      OP_ADDI: begin
        sum = {1'b0, acc} + {1'b0, imm};
        result = sum[DW-1:0]; c = sum[DW]; acc_we = 1'b1; c_we = 1'b1;
      end
`ifdef TINY_CPU_SHIFT_EN
      OP_NOP:  begin
        if (imm[1:0] == 2'b01) begin
          result = {acc[DW-2:0], 1'b0}; c = acc[DW-1]; acc_we = 1'b1; c_we = 1'b1;
        end else if (imm[1:0] == 2'b10) begin
          result = {1'b0, acc[DW-1:1]}; c = acc[0]; acc_we = 1'b1; c_we = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/tiny_cpu_core.sv
// Tiny accumulator CPU with fetch, input and output handshakes.
// Optional shifter on opcode 0 enabled by defining TINY_CPU_SHIFT_EN.
module tiny_cpu_core
  import tiny_cpu_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int PCW   = DEF_PCW,
  parameter int NREGS = DEF_NREGS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  output logic            imem_req,
  output logic [PCW-1:0]  imem_addr,
  input  logic            imem_ack,
  input  logic [DW+3:0]   imem_data,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            halted
);

  localparam int RW = $clog2(NREGS);

  state_t          state_reg;
  logic [PCW-1:0]  pc_reg;
  logic [DW-1:0]   acc_reg;
  logic            z_reg;
  logic            c_reg;
  logic [DW+3:0]   instr_reg;
  logic [DW-1:0]   regs_reg [NREGS];
  logic            imem_req_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic [DW-1:0]   out_data_reg;
  logic            halted_reg;

  opcode_t         op;
  logic [DW-1:0]   operand;
  logic [RW-1:0]   ridx;
  logic [DW-1:0]   alu_result;
  logic            alu_z, alu_c, alu_acc_we, alu_c_we;
  logic            take_jump;
  logic            st_en;
  logic [NREGS-1:0] reg_we;
  logic [PCW-1:0]  pc_next;

  assign op      = opcode_t'(instr_reg[DW+3:DW]);
  assign operand = instr_reg[DW-1:0];
  assign ridx    = operand[RW-1:0];

  tiny_cpu_alu #(.DW(DW)) u_alu (
    .op     (op),
    .acc    (acc_reg),
    .imm    (operand),
    .rval   (regs_reg[ridx]),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c),
    .acc_we (alu_acc_we),
    .c_we   (alu_c_we)
  );

  always_comb begin
    take_jump = 1'b0;
    case (op)
      OP_JMP:  take_jump = 1'b1;
      OP_JZ:   take_jump = z_reg;
      OP_JC:   take_jump = c_reg;
      default: take_jump = 1'b0;
    endcase
  end

  assign pc_next = take_jump ? operand[PCW-1:0] : pc_reg + PCW'(1);
  assign st_en   = ena && (state_reg == S_EXEC) && (op == OP_ST);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg_we
    assign reg_we[gi] = st_en && (ridx == RW'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!rst_n)
        regs_reg[i] <= '0;
      else if (reg_we[i])
        regs_reg[i] <= acc_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_FETCH;
      pc_reg        <= '0;
      acc_reg       <= '0;
      z_reg         <= 1'b0;
      c_reg         <= 1'b0;
      instr_reg     <= '0;
      imem_req_reg  <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      halted_reg    <= 1'b0;
    end else if (ena) begin
      case (state_reg)
        S_FETCH: begin
          imem_req_reg <= 1'b1;
          // an ack only counts once the request is actually visible on the bus
          if (imem_req_reg && imem_ack) begin
            instr_reg    <= imem_data;
            imem_req_reg <= 1'b0;
            state_reg    <= S_EXEC;
          end
        end
        S_EXEC: begin
          pc_reg <= pc_next;
          if (alu_acc_we) begin
            acc_reg <= alu_result;
            z_reg   <= alu_z;
          end
          if (alu_c_we)
            c_reg <= alu_c;
          case (op)
            OP_IN: begin
              state_reg    <= S_INWAIT;
              in_ready_reg <= 1'b1;
            end
            OP_OUT: begin
              state_reg     <= S_OUTWAIT;
              out_valid_reg <= 1'b1;
              out_data_reg  <= acc_reg;
            end
            OP_HALT: begin
              state_reg  <= S_HALT;
              halted_reg <= 1'b1;
            end
            default: begin
              state_reg    <= S_FETCH;
              imem_req_reg <= 1'b1;
            end
          endcase
        end
        S_INWAIT: begin
          if (in_valid) begin
            acc_reg      <= in_data;
            z_reg        <= (in_data == '0);
            in_ready_reg <= 1'b0;
            imem_req_reg <= 1'b1;
            state_reg    <= S_FETCH;
          end
        end
        S_OUTWAIT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            imem_req_reg  <= 1'b1;
            state_reg     <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign imem_req  = imem_req_reg;
  assign imem_addr = pc_reg;
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign halted    = halted_reg;

endmodule

// File: tb/tb_tiny_cpu_core.sv
// Bench for tiny_cpu_core: directed and random programs checked against an instruction-level model.
module tb_tiny_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n, ena;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [11:0] imem_data;
  logic [7:0]  in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready, halted;

  tiny_cpu_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] prog [256];

  // instruction-level reference state
  int m_pc, m_acc, m_z, m_c, m_halted, m_in_pend;
  int m_r [4];
  int exp_out [$];
  int got_out [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int a = 0; a < 256; a++) prog[a] = 12'hF00;
  endtask

  task automatic model_exec(input logic [11:0] ins);
    int opc, opd, r, nxt;
    opc = int'(ins[11:8]);
    opd = int'(ins[7:0]);
    r   = opd % 4;
    nxt = (m_pc + 1) % 256;
    case (opc)
`ifdef TINY_CPU_SHIFT_EN
      0: begin
        if (opd % 4 == 1) begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; m_z = (m_acc == 0); end
        else if (opd % 4 == 2) begin m_c = m_acc % 2; m_acc = m_acc / 2; m_z = (m_acc == 0); end
      end
`endif
      1:  begin m_acc = opd; m_z = (m_acc == 0); end
      2:  begin m_c = (m_acc + m_r[r] > 255); m_acc = (m_acc + m_r[r]) % 256; m_z = (m_acc == 0); end
      3:  begin m_c = (m_acc < m_r[r]); m_acc = (m_acc - m_r[r] + 256) % 256; m_z = (m_acc == 0); end
      4:  begin m_acc = m_acc & m_r[r]; m_z = (m_acc == 0); end
      5:  begin m_acc = m_acc | m_r[r]; m_z = (m_acc == 0); end
      6:  begin m_acc = m_acc ^ m_r[r]; m_z = (m_acc == 0); end
      7:  m_r[r] = m_acc;
      8:  begin m_acc = m_r[r]; m_z = (m_acc == 0); end
      9:  begin m_c = (m_acc + opd > 255); m_acc = (m_acc + opd) % 256; m_z = (m_acc == 0); end
      10: nxt = opd;
      11: if (m_z != 0) nxt = opd;
      12: if (m_c != 0) nxt = opd;
      13: m_in_pend = 1;
      14: exp_out.push_back(m_acc);
      15: m_halted = 1;
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // Resets the core, then runs prog with a randomly behaving memory and I/O partner until HALT.
  task automatic run_prog(input string name, input int budget, input int in_hold,
                          input int in_fixed, input bit ena_rand);
    int cyc, rdy_cnt, n_fetch;
    bit done, f_now, i_now, o_now;
    logic [7:0] f_addr, i_dat, o_dat;
    rst_n = 1'b0; ena = 1'b1; imem_ack = 1'b0; imem_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq({name, ":rst_req"},       imem_req,  0);
    check_eq({name, ":rst_addr"},      imem_addr, 0);
    check_eq({name, ":rst_in_ready"},  in_ready,  0);
    check_eq({name, ":rst_out_valid"}, out_valid, 0);
    check_eq({name, ":rst_out_data"},  out_data,  0);
    check_eq({name, ":rst_halted"},    halted,    0);
    rst_n = 1'b1;
    m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_halted = 0; m_in_pend = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    exp_out.delete();
    got_out.delete();
    cyc = 0; rdy_cnt = 0; n_fetch = 0; done = 1'b0;
    while (!done) begin
      if (cyc >= budget) begin
        check_eq({name, ":timeout_halted"}, halted, 1);
        break;
      end
      ena       = ena_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
      imem_ack  = imem_req && ($urandom_range(0, 2) != 0);
      imem_data = prog[imem_addr];
      in_data   = (in_fixed >= 0) ? in_fixed[7:0] : 8'($urandom);
      if (in_ready) rdy_cnt++;
      in_valid  = (in_hold > 0) ? (rdy_cnt > in_hold) : ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      if (in_ready) check_eq({name, ":in_ready_expected"}, in_ready, m_in_pend);
      if (out_valid) begin
        if (exp_out.size() == 0) check_eq({name, ":out_unexpected"}, out_valid, 0);
        else check_eq({name, ":out_data"}, out_data, exp_out[0]);
      end
      if (halted) begin
        check_eq({name, ":halted"},       halted, m_halted);
        check_eq({name, ":outs_pending"}, exp_out.size(), 0);
        check_eq({name, ":halt_req"},     imem_req, 0);
        check_eq({name, ":halt_in_rdy"},  in_ready, 0);
        check_eq({name, ":halt_out_vld"}, out_valid, 0);
        done = 1'b1;
      end else begin
        f_now = ena && imem_req && imem_ack;   f_addr = imem_addr;
        i_now = ena && in_ready && in_valid;   i_dat  = in_data;
        o_now = ena && out_valid && out_ready; o_dat  = out_data;
        @(posedge clk);
        #1;
        cyc++;
        if (f_now) begin
          check_eq({name, ":fetch_pc"}, f_addr, m_pc);
          model_exec(prog[f_addr]);
          n_fetch++;
        end
        if (i_now) begin
          m_acc = int'(i_dat); m_z = (m_acc == 0); m_in_pend = 0;
        end
        if (o_now) begin
          got_out.push_back(int'(o_dat));
          if (exp_out.size() > 0) void'(exp_out.pop_front());
          $display("[%0t] %s: OUT %02h", $time, name, o_dat);
        end
      end
    end
    $display("[%0t] %s: done after %0d cycles, %0d fetches, %0d outputs", $time, name, cyc, n_fetch, got_out.size());
  endtask

  task automatic gen_random(input int len);
    int op, opd;
    clear_prog();
    for (int a = 0; a < len - 2; a++) begin
      op  = $urandom_range(0, 14);
      opd = $urandom_range(0, 255);
      if (op >= 10 && op <= 12) opd = $urandom_range(a + 1, len - 2);
      prog[a] = {op[3:0], opd[7:0]};
    end
    prog[len-2] = 12'hE00;
    prog[len-1] = 12'hF00;
  endtask

  task automatic test_reset_ena();
    int w;
    clear_prog();
    prog[0] = 12'h109; prog[1] = 12'hE00; prog[2] = 12'hF00;
    rst_n = 1'b0; ena = 1'b1; imem_ack = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    w = 0;
    while (!out_valid && w < 100) begin
      imem_ack  = imem_req;
      imem_data = prog[imem_addr];
      @(posedge clk);
      #1;
      w++;
    end
    imem_ack = 1'b0;
    check_eq("rst_out:valid_seen", out_valid, 1);
    check_eq("rst_out:data", out_data, 8'h09);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_out:valid_low", out_valid, 0);
    check_eq("rst_out:addr", imem_addr, 0);
    check_eq("rst_out:req_low", imem_req, 0);
    rst_n = 1'b1;
    w = 0;
    while (!imem_req && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    check_eq("rst_out:req_back", imem_req, 1);
    check_eq("rst_out:pc_zero", imem_addr, 0);
    ena = 1'b0; imem_ack = 1'b1; imem_data = prog[0];
    repeat (5) begin
      @(posedge clk);
      #1;
      check_eq("freeze:addr", imem_addr, 0);
      check_eq("freeze:req", imem_req, 1);
    end
    ena = 1'b1; imem_ack = 1'b0;
    @(posedge clk);
    #1;
    check_eq("freeze:no_fetch", imem_req, 1);
    $display("[%0t] reset/enable sequence done", $time);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; imem_ack = 1'b0; imem_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    clear_prog();
    prog[0] = 12'h105; prog[1] = 12'h903; prog[2] = 12'hE00; prog[3] = 12'hF00;
    run_prog("ldi_addi_out", 500, 0, -1, 1'b0);
    check_eq("ldi_addi_out:n_out", got_out.size(), 1);
    if (got_out.size() >= 1) check_eq("ldi_addi_out:value", got_out[0], 8);

    clear_prog();
    prog[0] = 12'h1FF; prog[1] = 12'h901; prog[2] = 12'hC06; prog[6] = 12'hE00; prog[7] = 12'hF00;
    run_prog("carry_jc", 500, 0, -1, 1'b0);
    check_eq("carry_jc:n_out", got_out.size(), 1);
    if (got_out.size() >= 1) check_eq("carry_jc:value", got_out[0], 0);

    clear_prog();
    prog[0] = 12'h103; prog[1] = 12'h701; prog[2] = 12'h105; prog[3] = 12'h301;
    prog[4] = 12'hE00; prog[5] = 12'hC09; prog[6] = 12'h102; prog[7] = 12'h301;
    prog[8] = 12'hC0A; prog[10] = 12'hE00; prog[11] = 12'hF00;
    run_prog("sub_borrow", 500, 0, -1, 1'b0);
    check_eq("sub_borrow:n_out", got_out.size(), 2);
    if (got_out.size() >= 2) begin
      check_eq("sub_borrow:first", got_out[0], 8'h02);
      check_eq("sub_borrow:second", got_out[1], 8'hFF);
    end

    clear_prog();
    prog[0] = 12'hD00; prog[1] = 12'hE00; prog[2] = 12'hF00;
    run_prog("in_wait", 500, 10, 8'h5A, 1'b0);
    check_eq("in_wait:n_out", got_out.size(), 1);
    if (got_out.size() >= 1) check_eq("in_wait:value", got_out[0], 8'h5A);

    clear_prog();
    prog[0] = 12'hC10; prog[1] = 12'h1FF; prog[2] = 12'h901; prog[3] = 12'hAFE;
    prog[8'hFE] = 12'h000; prog[8'hFF] = 12'hE00; prog[8'h10] = 12'hF00;
    run_prog("pc_wrap", 500, 0, -1, 1'b0);
    check_eq("pc_wrap:n_out", got_out.size(), 1);

    clear_prog();
    prog[0] = 12'h181; prog[1] = 12'h001; prog[2] = 12'hE00; prog[3] = 12'hF00;
    run_prog("shift_op0", 500, 0, -1, 1'b0);
    check_eq("shift_op0:n_out", got_out.size(), 1);
`ifdef TINY_CPU_SHIFT_EN
    if (got_out.size() >= 1) check_eq("shift_op0:value", got_out[0], 8'h02);
`else
    if (got_out.size() >= 1) check_eq("shift_op0:value", got_out[0], 8'h81);
`endif

    for (int k = 0; k < 25; k++) begin
      gen_random(24);
      run_prog($sformatf("rnd%0d", k), 3000, 0, -1, 1'b1);
    end

    test_reset_ena();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
